// File: rtl/bpf_biquad_mc.sv
// Time-multiplexed biquad IIR filter, shared coefficients across channels.
// Two-stage pipeline: sample capture, then recursion, state write and output.
module bpf_biquad_mc #(
    parameter int NCH    = 2,
    parameter int IN_W   = 13,
    parameter int OUT_W  = 14,
    parameter int ACC_W  = 22,
    parameter int FRAC   = 8,
    parameter int COEF_W = 12
) (
    input  logic                                   clk1d25MHz,
    input  logic                                   rst,
    input  logic                                   in_valid,
    input  logic [(NCH > 1 ? $clog2(NCH) : 1)-1:0] in_ch,
    input  logic signed [IN_W-1:0]                 in_data,
    input  logic                                   cfg_we,
    input  logic [1:0]                             cfg_sel,
    input  logic signed [COEF_W-1:0]               cfg_data,
    output logic                                   out_valid,
    output logic [(NCH > 1 ? $clog2(NCH) : 1)-1:0] out_ch,
    output logic signed [OUT_W-1:0]                out_data,
    output logic                                   ovf
);

    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PW = ACC_W + COEF_W + 2;
    localparam int GW = COEF_W + IN_W + 4;
    localparam int SW = (PW > GW) ? PW : GW;

    localparam logic signed [SW-1:0] UMAX =
        {{(SW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [SW-1:0] UMIN =
        {{(SW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
    localparam logic signed [SW-1:0] OMAX =
        {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SW-1:0] OMIN =
        {{(SW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [COEF_W-1:0] g_q, a1_q, a2_q;
    logic                     mode_q;

    logic                     s1_v;
    logic [CW-1:0]            s1_ch;
    logic signed [IN_W-1:0]   s1_x;
    logic signed [COEF_W-1:0] s1_g, s1_a1, s1_a2;
    logic                     s1_mode;

    logic signed [ACC_W-1:0]  u1_q [NCH];
    logic signed [ACC_W-1:0]  u2_q [NCH];
    logic signed [IN_W-1:0]   x1_q [NCH];
    logic signed [IN_W-1:0]   x2_q [NCH];

    logic                     accept;
    logic                     ovf_clr;

    logic signed [SW-1:0]     xe, xe1, xe2, ge, a1e, a2e, u1e, u2e;
    logic signed [SW-1:0]     num, fb, fbs, un, ye;
    logic signed [ACC_W-1:0]  us;
    logic signed [OUT_W-1:0]  yo;
    logic                     sat_u, sat_o;

    assign accept  = in_valid && (int'(in_ch) < NCH);
    assign ovf_clr = cfg_we && (cfg_sel == 2'd3);

    // Shared coefficient and mode registers, written one field at a time.
    always_ff @(posedge clk1d25MHz) begin
        if (rst) begin
            g_q    <= COEF_W'(6);
            a1_q   <= COEF_W'(478);
            a2_q   <= COEF_W'(245);
            mode_q <= 1'b0;
        end else if (cfg_we) begin
            case (cfg_sel)
                2'd0:    g_q    <= cfg_data;
                2'd1:    a1_q   <= cfg_data;
                2'd2:    a2_q   <= cfg_data;
                default: mode_q <= cfg_data[0];
            endcase
        end
    end

    // Stage 1: capture the sample with a snapshot of the current coefficients.
    always_ff @(posedge clk1d25MHz) begin
        if (rst) begin
            s1_v    <= 1'b0;
            s1_ch   <= '0;
            s1_x    <= '0;
            s1_g    <= '0;
            s1_a1   <= '0;
            s1_a2   <= '0;
            s1_mode <= 1'b0;
        end else begin
            s1_v <= accept;
            if (accept) begin
                s1_ch   <= in_ch;
                s1_x    <= in_data;
                s1_g    <= g_q;
                s1_a1   <= a1_q;
                s1_a2   <= a2_q;
                s1_mode <= mode_q;
            end
        end
    end

    // Stage 2 arithmetic: full-precision recursion with saturation.
    always_comb begin
        xe  = SW'(s1_x);
        xe1 = SW'(x1_q[s1_ch]);
        xe2 = SW'(x2_q[s1_ch]);
        ge  = SW'(s1_g);
        a1e = SW'(s1_a1);
        a2e = SW'(s1_a2);
        u1e = SW'(u1_q[s1_ch]);
        u2e = SW'(u2_q[s1_ch]);
        if (s1_mode) num = xe + (xe1 <<< 1) + xe2;
        else         num = xe - xe2;
        fb  = (a1e * u1e) - (a2e * u2e);
        fbs = fb >>> FRAC;
        un  = fbs + (ge * num);
        sat_u = 1'b0;
        if (un > UMAX) begin
            us    = UMAX[ACC_W-1:0];
            sat_u = 1'b1;
        end else if (un < UMIN) begin
            us    = UMIN[ACC_W-1:0];
            sat_u = 1'b1;
        end else begin
            us = un[ACC_W-1:0];
        end
        ye    = SW'(us) >>> FRAC;
        sat_o = 1'b0;
        if (ye > OMAX) begin
            yo    = OMAX[OUT_W-1:0];
            sat_o = 1'b1;
        end else if (ye < OMIN) begin
            yo    = OMIN[OUT_W-1:0];
            sat_o = 1'b1;
        end else begin
            yo = ye[OUT_W-1:0];
        end
    end

    // Stage 2 commit: channel state, registered outputs and sticky overflow.
    always_ff @(posedge clk1d25MHz) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                u1_q[i] <= '0;
                u2_q[i] <= '0;
                x1_q[i] <= '0;
                x2_q[i] <= '0;
            end
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
            ovf       <= 1'b0;
        end else begin
            out_valid <= s1_v;
            if (s1_v) begin
                u1_q[s1_ch] <= us;
                u2_q[s1_ch] <= u1_q[s1_ch];
                x1_q[s1_ch] <= s1_x;
                x2_q[s1_ch] <= x1_q[s1_ch];
                out_ch      <= s1_ch;
                out_data    <= yo;
            end
            ovf <= (ovf && !ovf_clr) || (s1_v && (sat_u || sat_o));
        end
    end

endmodule
